mux_arb_n_to_1: RTL and testbench
=================================

# mux_arb_n_to_1

Parametrised N-input, WIDTH-bit registered multiplexer with per-channel valid/ready handshake. Picks one input per cycle, either by an explicit select or by round-robin arbitration, and holds the result in a single output register until the consumer accepts it. It generalises the fixed 8-to-1, 1-bit combinational select used in the datapath. Typical uses are writeback-source merging and sharing one memory port between multiple requesters.

## Interface
Parameters:
- WIDTH, 32, data bits per channel
- NUM_IN, 8, number of input channels (≥2; need not be a power of two)
- SEL_W, $clog2(NUM_IN), select/source index width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = explicit select, 1 = round-robin
- sel  input  SEL_W  channel index used in select mode
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready (one-hot or zero)
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data
- out_src  output  SEL_W  index of the channel that produced out_data

## Operation
- Two states, encoded by out_valid: EMPTY (0) and FULL (1).
- load_en = !out_valid | out_ready.
- Grant logic (combinational):
  - Select mode:
    - grant = sel.
    - grant_vld = in_valid[sel] and sel < NUM_IN.
    - An out-of-range sel gives no grant.
  - Round-robin mode:
    - grant is the first i with in_valid[i], searching upward from (ptr+1) mod NUM_IN and wrapping.
    - grant_vld = |in_valid.
- Ready: in_ready[i] = load_en & grant_vld & (i == grant). in_ready never depends on in_valid of any other channel in select mode.
- Transfer when in_valid[grant] & in_ready[grant]:
  - out_data <= in_data[grant]
  - out_src <= grant
  - out_valid <= 1
  - in round-robin mode, ptr <= grant
- State transitions:
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY when out_ready and no transfer.
  - FULL→FULL when out_ready and a transfer happen in the same cycle (back-to-back). The register is overwritten and out_valid stays 1.
  - FULL with !out_ready: hold everything. All in_ready = 0.
- ptr updates only on a round-robin transfer. Select-mode transfers leave ptr unchanged.
- Changes to mode or sel take effect at the next grant evaluation. The held output is never altered.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=NUM_IN-1 (so the first round-robin search starts at channel 0).
- rst asserted mid-transfer: any held data is dropped. All outputs take their reset values on the next edge.
- Latency is 1 cycle from an input handshake to out_valid.
- Throughput is 1 transfer per cycle when out_ready is held high.
- in_ready is combinational from out_valid, out_ready, mode, sel, in_valid and ptr. There is no combinational path from in_data to any output.

## Configuration
- MUX_ARB_RR_EN defined: round-robin logic and ptr are compiled in, and mode operates as described.
- MUX_ARB_RR_EN undefined:
  - ptr and the rotate logic are removed.
  - The mode input is ignored and the block always behaves in select mode.
  - The port list is unchanged.

## Structure
- Shared include mux_arb_defs.vh holds:
  - MODE_SEL=1'b0 and MODE_RR=1'b1 constants
  - the flattened-bus slice macro
- Sub-module rr_pick (parameters NUM_IN and SEL_W):
  - inputs: valid vector and ptr
  - outputs: grant and grant_vld
  - purely combinational, implemented as a rotate, priority-encode, un-rotate
  - instantiated only under MUX_ARB_RR_EN

## Test plan
- Reset: hold rst for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_src=0, in_ready=0 throughout.
- Select mode, WIDTH=32, NUM_IN=8: sel=5, in_valid=8'h20, in_data[5]=32'hDEADBEEF, out_ready=1 → in_ready=8'h20 for one cycle; the next cycle gives out_valid=1, out_data=32'hDEADBEEF, out_src=5.
- Backpressure: FULL with out_ready=0 for 4 cycles while in_valid=8'hFF → in_ready=0 and out_data stable. Raising out_ready then produces one back-to-back reload with out_valid remaining 1.
- Round-robin fairness: mode=1, in_valid=8'hFF, out_ready=1 for 10 cycles → out_src sequence 0,1,2,…,7,0,1.
- Round-robin skip and wrap: in_valid=8'b1000_0101 with ptr=2 after a grant to channel 2 → next grants 7, then 0, then 2.
- Select corner cases: NUM_IN=6, sel=7 → no in_ready asserted and out_valid stays 0. Separately, sel=3 with in_valid[3]=0 but in_valid[0]=1 → in_ready=0.

Source files
------------

// File: rtl/mux_arb_n_to_1_pkg.sv
// Types shared by the mux_arb_n_to_1 block.
// Output-register state: the encoding matches out_valid directly.
package mux_arb_n_to_1_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/mux_arb_defs.vh
// Shared constants and helpers for the mux_arb_n_to_1 block.
//   MODE_SEL / MODE_RR : values of the mode input
//   MUX_ARB_SLICE      : pick element idx (w bits wide) out of a flattened bus
`ifndef MUX_ARB_DEFS_VH
`define MUX_ARB_DEFS_VH

`define MODE_SEL 1'b0
`define MODE_RR  1'b1

`define MUX_ARB_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

`endif

// File: rtl/rr_pick.sv
// Round-robin picker: first valid channel searching upward from ptr+1
// (mod NUM_IN), wrapping. Purely combinational.
//   valid     : per-channel request vector
//   ptr       : last granted channel
//   grant     : chosen channel index
//   grant_vld : any request present
module rr_pick #(
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] valid,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_vld
);
    // One extra bit so start+offset (up to 2*NUM_IN-2) cannot overflow.
    localparam int IW = SEL_W + 1;

    logic [IW-1:0]       start;
    logic [2*NUM_IN-1:0] dbl;
    logic [NUM_IN-1:0]   rot;
    logic [IW-1:0]       off;
    logic [IW-1:0]       sum;

    always_comb begin
        // Explicit wrap: NUM_IN need not be a power of two.
        start = ({1'b0, ptr} == IW'(NUM_IN - 1)) ? '0 : {1'b0, ptr} + IW'(1);
        // Rotate so the search origin lands at bit 0.
        dbl   = {valid, valid} >> start;
        rot   = dbl[NUM_IN-1:0];
        // Lowest set bit wins: scan downward so the last hit is the lowest.
        off   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        // Un-rotate.
        sum = start + off;
        if (sum >= IW'(NUM_IN)) sum = sum - IW'(NUM_IN);
        grant     = sum[SEL_W-1:0];
        grant_vld = |valid;
    end

endmodule

// File: rtl/mux_arb_n_to_1.sv
// N-input registered mux with per-channel valid/ready. One channel is picked
// per cycle (explicit select or round-robin) and held in a single output
// register until the consumer accepts it.
// Build option: define MUX_ARB_RR_EN to compile in round-robin mode; without
// it the mode input is ignored and the block always selects by sel.
//   clk, rst             : clock, synchronous active-high reset
//   mode                 : 0 select, 1 round-robin
//   sel                  : channel index for select mode
//   in_data/valid/ready  : flattened input channels and handshake
//   out_data/valid/ready : registered output and handshake
//   out_src              : channel index that produced out_data
`include "mux_arb_defs.vh"

module mux_arb_n_to_1
    import mux_arb_n_to_1_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   src_q;
    logic [SEL_W-1:0]   grant;
    logic               grant_vld;
    logic               sel_vld;
    logic               load_en;
    logic               xfer;
    logic [WIDTH-1:0]   grant_data;

    // Select-mode validity via compare loop: an out-of-range sel matches
    // nothing and so never grants.
    always_comb begin
        sel_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) sel_vld = in_valid[i];
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_vld;
    logic             rr_mode;

    rr_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_rr_pick (
        .valid     (in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_vld (rr_vld)
    );

    assign rr_mode   = (mode == `MODE_RR);
    assign grant     = rr_mode ? rr_grant : sel;
    assign grant_vld = rr_mode ? rr_vld : sel_vld;

    // Reset to the last channel so the first search starts at channel 0.
    always_ff @(posedge clk) begin
        if (rst)                ptr_q <= SEL_W'(NUM_IN - 1);
        else if (xfer && rr_mode) ptr_q <= grant;
    end
`else
    logic unused_mode;
    assign unused_mode = (mode == `MODE_SEL);
    assign grant       = sel;
    assign grant_vld   = sel_vld;
`endif

    assign load_en = (state_q == ST_EMPTY) | out_ready;

    // Reset gating keeps in_ready low while rst is held.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && grant_vld) begin
            for (int i = 0; i < NUM_IN; i++) begin
                in_ready[i] = (grant == SEL_W'(i));
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) grant_data = `MUX_ARB_SLICE(in_data, i, WIDTH);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer)               state_d = ST_FULL;
            ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
            default:                          state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                data_q <= grant_data;
                src_q  <= grant;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench for mux_arb_n_to_1: expected outputs go into a scoreboard
// queue as stimulus is issued; a negedge monitor pops and compares on every
// accepted output. A second 6-channel instance covers out-of-range select.
module tb_mux_arb_n_to_1;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [SW-1:0]  out_src;

    logic [SW-1:0]   sel6 = '0;
    logic [N6*W-1:0] in_data6;
    logic [N6-1:0]   in_valid6;
    logic [N6-1:0]   in_ready6;
    logic [W-1:0]    out_data6;
    logic            out_valid6;
    logic            out_ready6 = 1'b1;
    logic [SW-1:0]   out_src6;

    always #5 clk = ~clk;

    mux_arb_n_to_1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src)
    );

    mux_arb_n_to_1 #(.WIDTH(W), .NUM_IN(N6), .SEL_W(SW)) u_dut6 (
        .clk(clk), .rst(rst), .mode(1'b0), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready6),
        .out_src(out_src6)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] src;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] chdat(input int i);
        return 32'hA000_0000 + W'(i);
    endfunction

    task automatic push(input logic [W-1:0] d, input int s);
        exp_t e;
        e.data = d;
        e.src  = SW'(s);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got src %0d data %h, want no output", out_src, out_data);
            end else begin
                e = sb.pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_src", W'(out_src), W'(e.src));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++)  in_data[i*W +: W]  = chdat(i);
        for (int i = 0; i < N6; i++) in_data6[i*W +: W] = 32'hB000_0000 + W'(i);
        in_valid  = '1;
        in_valid6 = '1;
        out_ready = 1'b1;

        // Reset with every channel requesting: nothing may be granted.
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", W'(out_valid), 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_src", W'(out_src), 0);
            chk("rst_in_ready", W'(in_ready), 0);
            chk("rst_in_ready6", W'(in_ready6), 0);
            step();
        end
        rst       = 1'b0;
        in_valid  = '0;
        in_valid6 = '0;

        // Basic select transfer.
        mode = 1'b0; sel = 3'd5; in_valid = 8'h20;
        in_data[5*W +: W] = 32'hDEADBEEF;
        push(32'hDEADBEEF, 5);
        @(negedge clk); chk("sel_in_ready", W'(in_ready), 32'h20);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("sel_out_valid", W'(out_valid), 1);
        chk("sel_in_ready_idle", W'(in_ready), 0);
        step();
        in_data[5*W +: W] = chdat(5);

        // Backpressure: hold with all requesting, then a back-to-back reload.
        sel = 3'd2; in_valid = 8'hFF;
        push(chdat(2), 2);
        @(negedge clk); chk("bp_load_ready", W'(in_ready), 32'h04);
        step();
        out_ready = 1'b0;
        in_data[2*W +: W] = 32'h1234_5678;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", W'(in_ready), 0);
            chk("bp_out_data", out_data, chdat(2));
            chk("bp_out_valid", W'(out_valid), 1);
            step();
        end
        in_data[2*W +: W] = chdat(2);
        out_ready = 1'b1; sel = 3'd4;
        push(chdat(4), 4);
        @(negedge clk); chk("b2b_in_ready", W'(in_ready), 32'h10);
        step();
        in_valid = '0;
        @(negedge clk); chk("b2b_out_valid", W'(out_valid), 1);
        step();
        @(negedge clk); chk("drain_out_valid", W'(out_valid), 0);
        step();

        // Select corners: requested channel idle; out-of-range sel on 6 inputs.
        sel = 3'd3; in_valid = 8'h01;
        sel6 = 3'd7; in_valid6 = 6'h3F;
        @(negedge clk);
        chk("sel_idle_ready", W'(in_ready), 0);
        chk("oor_in_ready6", W'(in_ready6), 0);
        step();
        @(negedge clk);
        chk("sel_idle_valid", W'(out_valid), 0);
        chk("oor_out_valid6", W'(out_valid6), 0);
        step();
        in_valid = '0;
        sel6 = 3'd5;
        @(negedge clk); chk("n6_in_ready", W'(in_ready6), 32'h20);
        step();
        in_valid6 = '0;
        @(negedge clk);
        chk("n6_out_valid", W'(out_valid6), 1);
        chk("n6_out_data", out_data6, 32'hB000_0005);
        chk("n6_out_src", W'(out_src6), 5);
        step();

`ifdef MUX_ARB_RR_EN
        // Round-robin fairness from reset pointer: 0..7, 0, 1.
        mode = 1'b1; in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            push(chdat(k % 8), k % 8);
            @(negedge clk); chk("rr_fair_ready", W'(in_ready), W'(1) << (k % 8));
            step();
        end
        // Park ptr on 2, then skip/wrap over 8'b1000_0101: 7, 0, 2.
        in_valid = 8'h04;
        push(chdat(2), 2);
        @(negedge clk); chk("rr_ptr2_ready", W'(in_ready), 32'h04);
        step();
        in_valid = 8'h85;
        push(chdat(7), 7);
        @(negedge clk); chk("rr_wrap_ready7", W'(in_ready), 32'h80);
        step();
        push(chdat(0), 0);
        @(negedge clk); chk("rr_wrap_ready0", W'(in_ready), 32'h01);
        step();
        push(chdat(2), 2);
        @(negedge clk); chk("rr_wrap_ready2", W'(in_ready), 32'h04);
        step();
`else
        // Without round-robin support the mode input must be ignored.
        mode = 1'b1; sel = 3'd3; in_valid = 8'hFF;
        repeat (3) begin
            push(chdat(3), 3);
            @(negedge clk); chk("nomode_ready3", W'(in_ready), 32'h08);
            step();
        end
        sel = 3'd7; in_valid = 8'h85;
        push(chdat(7), 7);
        @(negedge clk); chk("nomode_ready7", W'(in_ready), 32'h80);
        step();
        sel = 3'd1;
        @(negedge clk); chk("nomode_idle", W'(in_ready), 0);
        step();
`endif
        in_valid = '0; mode = 1'b0;
        @(negedge clk);
        step();

        // Reset while holding data: the held word is dropped, never delivered.
        sel = 3'd6; in_valid = 8'h40; out_ready = 1'b0;
        @(negedge clk); chk("mid_load_ready", W'(in_ready), 32'h40);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("mid_held_valid", W'(out_valid), 1);
        chk("mid_held_data", out_data, chdat(6));
        step();
        rst = 1'b1; in_valid = 8'hFF;
        @(negedge clk); chk("mid_rst_ready", W'(in_ready), 0);
        step();
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", W'(out_valid), 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_src", W'(out_src), 0);
        step();

        // After reset channel 0 wins first (ptr reset in RR, sel=0 otherwise).
        mode = 1'b1; sel = 3'd0; in_valid = 8'hFF;
        push(chdat(0), 0);
        @(negedge clk); chk("post_rst_ready", W'(in_ready), 32'h01);
        step();
        in_valid = '0; mode = 1'b0;
        repeat (2) step();

        chk("sb_empty", W'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
